// File: rtl/seq_1101_pkg.sv
// Shared definitions for the 1101 frame transmitter and its detector.
// Both ends take the preamble from here so the pattern cannot drift.
package seq_1101_pkg;

  localparam logic [3:0] PREAMBLE = 4'b1101;
  localparam int         PRE_LEN  = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAR,
    GAP
  } state_e;

endpackage

// File: rtl/seq_frame_tx_1101_if.sv
// Payload handshake and serial line bundle for seq_frame_tx_1101.
// The master side offers payloads, and the transmitter is the slave side.
interface seq_frame_tx_1101_if #(
  parameter int PAYLOAD_W = 8
);

  logic                 load;
  logic [PAYLOAD_W-1:0] payload;
  logic                 ready;
  logic                 busy;
  logic                 dout;
  logic                 frame_done;

  modport master (
    output load,
    output payload,
    input  ready,
    input  busy,
    input  dout,
    input  frame_done
  );

  modport slave (
    input  load,
    input  payload,
    output ready,
    output busy,
    output dout,
    output frame_done
  );

endinterface

// File: rtl/seq_frame_tx_1101_piso.sv
// Parallel-in serial-out register, MSB first, synchronous active-low clear.
// so always shows the bit that the next shift will consume.
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic         sh,
  input  logic [W-1:0] din,
  output logic         so
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (ld) begin
      sr_d = din;
    end else if (sh) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign so = sr_q[W-1];

endmodule

// File: rtl/seq_frame_tx_1101.sv
// 1101-preamble serial frame transmitter with idle gap between frames.
// Define PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx_1101
  import seq_1101_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int GAP       = 2
) (
  input logic                clk,
  input logic                reset,
  seq_frame_tx_1101_if.slave bus
);

  localparam int CW = $clog2(PAYLOAD_W + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam state_e S_GAP = seq_1101_pkg::GAP;

  state_e        state_q, state_d;
  logic [1:0]    pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          dout_q, dout_d;
  logic          fd_q, fd_d;
  logic          ld;
  logic          sh;
  logic          so;
  logic          ready_c;

`ifdef PARITY_EN
  localparam bit HAS_PAR = 1'b1;
  logic par_q, par_d;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  piso_shift_reg #(
    .W (PAYLOAD_W)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .ld    (ld),
    .sh    (sh),
    .din   (bus.payload),
    .so    (so)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      dout_q  <= 1'b0;
      fd_q    <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      dout_q  <= dout_d;
      fd_q    <= fd_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // dout_d is the bit the line carries in the cycle after this edge.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    dout_d  = 1'b0;
    fd_d    = 1'b0;
    ld      = 1'b0;
    sh      = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          state_d = PRE;
          pre_d   = '0;
          cnt_d   = '0;
          ld      = 1'b1;
          dout_d  = PREAMBLE[PRE_LEN-1];
`ifdef PARITY_EN
          par_d   = ^bus.payload;
`endif
        end
      end
      PRE: begin
        if (pre_q == 2'(PRE_LEN - 1)) begin
          state_d = DATA;
          cnt_d   = CW'(1);
          sh      = 1'b1;
          dout_d  = so;
          fd_d    = !HAS_PAR && (PAYLOAD_W == 1);
        end else begin
          pre_d  = pre_q + 2'd1;
          dout_d = PREAMBLE[2'd2 - pre_q];
        end
      end
      DATA: begin
        if (cnt_q != CW'(PAYLOAD_W)) begin
          sh     = 1'b1;
          dout_d = so;
          cnt_d  = cnt_q + 1'b1;
          fd_d   = !HAS_PAR &&
                   ((cnt_q + 1'b1) == CW'(PAYLOAD_W));
        end else begin
`ifdef PARITY_EN
          state_d = PAR;
          dout_d  = par_q;
          fd_d    = 1'b1;
`else
          cnt_d = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = GW'(1);
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef PARITY_EN
      PAR: begin
        cnt_d = '0;
        if (GAP > 0) begin
          state_d = S_GAP;
          gcnt_d  = GW'(1);
        end else begin
          state_d = IDLE;
        end
      end
`endif
      S_GAP: begin
        if (gcnt_q == GW'(GAP)) begin
          state_d = IDLE;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ready_c = (state_q == IDLE);
  end

  assign bus.ready      = ready_c;
  assign bus.busy       = ~ready_c;
  assign bus.dout       = dout_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seq_frame_tx_1101.sv
// Scoreboard bench: two transmitters (GAP=2 and GAP=0) checked every cycle.
// Expected line state is queued at acceptance and popped by the monitor.
module tb_seq_frame_tx_1101;

`ifdef PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_frame_tx_1101_if #(.PAYLOAD_W(8)) ba ();
  seq_frame_tx_1101_if #(.PAYLOAD_W(8)) bb ();

  seq_frame_tx_1101 #(
    .PAYLOAD_W (8),
    .GAP       (2)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ba.slave)
  );

  seq_frame_tx_1101 #(
    .PAYLOAD_W (8),
    .GAP       (0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bb.slave)
  );

  // entry = {dout, frame_done, ready, busy}
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int total = 0;
  int bad   = 0;

  logic [3:0] win = 4'b0;
  int nbits = 0;
  int det   = 0;

  localparam logic [3:0] IDLE_E = 4'b0010;

  function automatic void push_frame(
    input bit         sel,
    input logic [7:0] p,
    input bit         par,
    input int         gap
  );
    logic [3:0] pre;
    logic [3:0] e[$];
    pre = 4'b1101;
    for (int i = 3; i >= 0; i--) e.push_back({pre[i], 3'b001});
    for (int i = 7; i >= 0; i--)
      e.push_back({p[i], (i == 0) && !HAS_PAR, 2'b01});
    if (HAS_PAR) e.push_back({par, 3'b101});
    for (int g = 0; g < gap; g++) e.push_back(4'b0001);
    foreach (e[k]) begin
      if (sel) qb.push_back(e[k]);
      else qa.push_back(e[k]);
    end
  endfunction

  task automatic check(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t dout/fd/rdy/busy got=%b required=%b",
               nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] p, input bit par);
    ba.load    = 1'b1;
    ba.payload = p;
    @(posedge clk);
    #1;
    push_frame(1'b0, p, par, 2);
    ba.load    = 1'b0;
    ba.payload = ~p;
  endtask

  initial begin
    logic [3:0] ea;
    logic [3:0] eb;
    @(posedge clk);
    forever begin
      @(negedge clk);
      ea = (qa.size() > 0) ? qa.pop_front() : IDLE_E;
      eb = (qb.size() > 0) ? qb.pop_front() : IDLE_E;
      check("line_a", {ba.dout, ba.frame_done, ba.ready, ba.busy}, ea);
      check("line_b", {bb.dout, bb.frame_done, bb.ready, bb.busy}, eb);
      win = {win[2:0], bb.dout};
      nbits++;
      if (nbits >= 4 && win == 4'b1101) begin
        det++;
        nbits = 0;
      end
    end
  end

  initial begin
    reset      = 1'b0;
    ba.load    = 1'b1;
    ba.payload = 8'hFF;
    bb.load    = 1'b1;
    bb.payload = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b1;
    ba.load = 1'b0;
    bb.load = 1'b0;
    cyc(6);

    // basic frame with a stray load during DATA
    send_a(8'hA5, 1'b0);
    cyc(5);
    ba.load    = 1'b1;
    ba.payload = 8'h00;
    cyc(1);
    ba.load = 1'b0;
    cyc(14);

    send_a(8'h07, 1'b1);
    cyc(20);

    // abort during the second preamble bit
    send_a(8'h96, 1'b0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    qa.delete();
    reset = 1'b1;
    cyc(3);
    send_a(8'h3C, 1'b0);
    cyc(20);

    // GAP=0 back-to-back with load held high
    bb.load    = 1'b1;
    bb.payload = 8'hFF;
    @(posedge clk);
    #1;
    push_frame(1'b1, 8'hFF, 1'b0, 0);
    bb.payload = 8'h00;
    cyc(13 + int'(HAS_PAR));
    push_frame(1'b1, 8'h00, 1'b0, 0);
    bb.load = 1'b0;
    cyc(20);

    total++;
    if (det != 2) begin
      bad++;
      $display("FAIL detect_count got=%0d required=2", det);
    end
    total++;
    if (qa.size() + qb.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d required=0",
               qa.size() + qb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
